// File: rtl/m_alu_barrel_shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | p_common : shared shift-operation types for the ALU operand path     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package p_common;

  // Widest shift amount carried in s_shift_op (WIDTH up to 256).
  localparam int c_amt_w_max = 8;

  typedef enum logic [2:0] {
    SHIFT_SHL  = 3'd0,
    SHIFT_SHR  = 3'd1,
    SHIFT_ASL  = 3'd2,
    SHIFT_ASR  = 3'd3,
    SHIFT_ROL  = 3'd4,
    SHIFT_ROR  = 3'd5,
    SHIFT_NONE = 3'd6
  } e_shift_type;

  typedef struct packed {
    e_shift_type              shift_type;
    logic [c_amt_w_max-1:0]   amount;
    logic                     sign;
  } s_shift_op;

endpackage
`default_nettype wire

// File: rtl/m_alu_barrel_shifter_shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m_alu_shift_stage : NUM_LAYERS log-shifter layers plus one elastic   |
// |                     pipeline register.  Revision : 1.0               |
// +----------------------------------------------------------------------+
module m_alu_shift_stage
  import p_common::*;
#(
  parameter int WIDTH       = 32,
  parameter int FIRST_LAYER = 0,
  parameter int NUM_LAYERS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  s_shift_op        in_op,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output s_shift_op        out_op,
  output logic             out_carry,
  output logic             out_zero
);

  logic [WIDTH-1:0] w_layer [NUM_LAYERS+1];
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  s_shift_op        r_op;
  logic             r_carry;
  logic             r_zero;

  assign w_layer[0] = in_data;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    localparam int c_sh = 1 << (FIRST_LAYER + i);
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_sel;

    assign w_in = w_layer[i];

    always_comb begin
      w_sel = w_in;
      if (in_op.amount[FIRST_LAYER + i]) begin
        case (in_op.shift_type)
          SHIFT_SHL, SHIFT_ASL: w_sel = {w_in[WIDTH-1-c_sh:0], {c_sh{1'b0}}};
          SHIFT_SHR:            w_sel = {{c_sh{1'b0}}, w_in[WIDTH-1:c_sh]};
          SHIFT_ASR:            w_sel = {{c_sh{in_op.sign}}, w_in[WIDTH-1:c_sh]};
          SHIFT_ROL:            w_sel = {w_in[WIDTH-1-c_sh:0], w_in[WIDTH-1:WIDTH-c_sh]};
          SHIFT_ROR:            w_sel = {w_in[c_sh-1:0], w_in[WIDTH-1:c_sh]};
          default:              w_sel = w_in;
        endcase
      end
    end

    assign w_layer[i+1] = w_sel;
  end

  // Stage advances when empty or when downstream takes the held result.
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data  <= w_layer[NUM_LAYERS];
        r_op    <= in_op;
        r_carry <= in_carry;
        r_zero  <= (w_layer[NUM_LAYERS] == '0);
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_op    = r_op;
  assign out_carry = r_carry;
  assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: rtl/m_alu_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m_alu_barrel_shifter : pipelined log barrel shifter with carry/zero  |
// |                        flags and valid/ready stalling. Rev : 1.0     |
// +----------------------------------------------------------------------+
module m_alu_barrel_shifter
  import p_common::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  localparam int AMT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  e_shift_type      in_type,
  input  logic [AMT_W-1:0] in_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int c_base  = AMT_W / STAGES;
  localparam int c_extra = AMT_W % STAGES;

  logic [WIDTH-1:0] w_data  [STAGES+1];
  s_shift_op        w_op    [STAGES+1];
  logic             w_valid [STAGES+1];
  logic             w_ready [STAGES+1];
  logic             w_carry [STAGES+1];
  logic             w_zero  [STAGES];

  s_shift_op        w_op_in;
  logic [AMT_W-1:0] w_left_idx;
  logic [AMT_W-1:0] w_right_idx;
  logic             w_carry_in;
  logic             w_unused;

  // Every carry rule reduces to one input bit: WIDTH-amount for the
  // left-moving types (rotate-left lands it in bit 0), amount-1 otherwise.
  assign w_left_idx  = ~in_amount + 1'b1;
  assign w_right_idx = in_amount - 1'b1;

  always_comb begin
    w_carry_in = 1'b0;
    if (in_amount != '0) begin
      case (in_type)
        SHIFT_SHL, SHIFT_ASL, SHIFT_ROL: w_carry_in = in_data[w_left_idx];
        SHIFT_SHR, SHIFT_ASR, SHIFT_ROR: w_carry_in = in_data[w_right_idx];
        default:                         w_carry_in = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_op_in            = '0;
    w_op_in.shift_type = in_type;
    w_op_in.amount     = c_amt_w_max'(in_amount);
    w_op_in.sign       = in_data[WIDTH-1];
  end

  assign w_data[0]       = in_data;
  assign w_op[0]         = w_op_in;
  assign w_valid[0]      = in_valid;
  assign w_carry[0]      = w_carry_in;
  assign w_ready[STAGES] = out_ready;
  assign in_ready        = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_first = k * c_base + ((k < c_extra) ? k : c_extra);
    localparam int c_num   = c_base + ((k < c_extra) ? 1 : 0);

    m_alu_shift_stage #(
      .WIDTH       (WIDTH),
      .FIRST_LAYER (c_first),
      .NUM_LAYERS  (c_num)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .in_data   (w_data[k]),
      .in_op     (w_op[k]),
      .in_carry  (w_carry[k]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1]),
      .out_data  (w_data[k+1]),
      .out_op    (w_op[k+1]),
      .out_carry (w_carry[k+1]),
      .out_zero  (w_zero[k])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign out_data  = w_data[STAGES];
  assign out_carry = w_carry[STAGES];
  assign out_zero  = w_zero[STAGES-1];

  assign w_unused = ^w_op[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_m_alu_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_m_alu_barrel_shifter : bench for three shifter configurations     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_m_alu_barrel_shifter;
  import p_common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  e_shift_type in_type;
  logic [63:0] din;
  logic [5:0]  amt;

  logic [31:0] od32;
  logic [15:0] od16;
  logic [63:0] od64;
  logic        ir32, ir16, ir64, ov32, ov16, ov64;
  logic        oc32, oc16, oc64, oz32, oz16, oz64;

  logic [63:0] od [3];
  logic        ir [3];
  logic        ov [3];
  logic        oc [3];
  logic        oz [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  m_alu_barrel_shifter #(.WIDTH(32), .STAGES(2)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
    .in_data(din[31:0]), .in_type(in_type), .in_amount(amt[4:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_data(od32),
    .out_carry(oc32), .out_zero(oz32));

  m_alu_barrel_shifter #(.WIDTH(16), .STAGES(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .in_data(din[15:0]), .in_type(in_type), .in_amount(amt[3:0]),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16),
    .out_carry(oc16), .out_zero(oz16));

  m_alu_barrel_shifter #(.WIDTH(64), .STAGES(6)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64),
    .in_data(din), .in_type(in_type), .in_amount(amt),
    .out_valid(ov64), .out_ready(out_ready), .out_data(od64),
    .out_carry(oc64), .out_zero(oz64));

  assign od[0] = {32'h0, od32};
  assign od[1] = {48'h0, od16};
  assign od[2] = od64;
  assign ir[0] = ir32;  assign ir[1] = ir16;  assign ir[2] = ir64;
  assign ov[0] = ov32;  assign ov[1] = ov16;  assign ov[2] = ov64;
  assign oc[0] = oc32;  assign oc[1] = oc16;  assign oc[2] = oc64;
  assign oz[0] = oz32;  assign oz[1] = oz16;  assign oz[2] = oz64;

  function automatic int wid(input int d);
    return (d == 0) ? 32 : (d == 1) ? 16 : 64;
  endfunction

  // Reference: each result bit named by where it comes from; {data, carry, zero}.
  function automatic logic [65:0] f_ref(input int w, input logic [63:0] d,
                                        input e_shift_type t, input int a);
    logic [63:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int j = 0; j < w; j++) begin
      case (t)
        SHIFT_SHL, SHIFT_ASL: r[j] = (j >= a) ? d[j-a] : 1'b0;
        SHIFT_SHR:            r[j] = (j + a < w) ? d[j+a] : 1'b0;
        SHIFT_ASR:            r[j] = (j + a < w) ? d[j+a] : d[w-1];
        SHIFT_ROL:            r[j] = d[(j - a + w) % w];
        SHIFT_ROR:            r[j] = d[(j + a) % w];
        default:              r[j] = d[j];
      endcase
    end
    if (a != 0) begin
      case (t)
        SHIFT_SHL, SHIFT_ASL: c = d[w-a];
        SHIFT_SHR, SHIFT_ASR: c = d[a-1];
        SHIFT_ROL:            c = r[0];
        SHIFT_ROR:            c = r[w-1];
        default:              c = 1'b0;
      endcase
    end
    return {r, c, (r == 64'h0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic randomize_inputs();
    in_type = e_shift_type'(3'($urandom_range(0, 7)));
    din     = {$urandom, $urandom};
    amt     = 6'($urandom_range(0, 63));
  endtask

  task automatic test_reset();
    #3;
    for (int d = 0; d < 3; d++) begin
      n_vec += 4;
      if (ov[d] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", d, ov[d]); end
      if (od[d] !== 64'h0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", d, od[d]); end
      if (oc[d] !== 1'b0) begin n_err++; $display("FAIL reset_carry[%0d]: got %b want 0", d, oc[d]); end
      if (oz[d] !== 1'b0) begin n_err++; $display("FAIL reset_zero[%0d]: got %b want 0", d, oz[d]); end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if (ir[d] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", d, ir[d]); end
    end
  endtask

  typedef struct {
    e_shift_type t;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] e;
    logic        c;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [12];
    tbl[0]  = '{SHIFT_SHL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    tbl[1]  = '{SHIFT_ASR, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
    tbl[2]  = '{SHIFT_SHR, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
    tbl[3]  = '{SHIFT_SHR, 32'h0000_0010, 5'd5,  32'h0000_0000, 1'b1};
    tbl[4]  = '{SHIFT_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1};
    tbl[5]  = '{SHIFT_ROL, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0};
    tbl[6]  = '{SHIFT_ASL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
    tbl[7]  = '{SHIFT_ASR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{SHIFT_NONE, 32'hCAFE_F00D, 5'd7, 32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{e_shift_type'(3'd7), 32'h0000_0F0F, 5'd3, 32'h0000_0F0F, 1'b0};
    tbl[10] = '{SHIFT_ASL, 32'hC000_0000, 5'd1,  32'h8000_0000, 1'b1};
    tbl[11] = '{SHIFT_ROR, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0};
    do_reset();
    for (int v = 0; v < 12; v++) begin
      in_valid = 1'b1;
      in_type  = tbl[v].t;
      din      = {32'h0, tbl[v].d};
      amt      = {1'b0, tbl[v].a};
      @(negedge clk);
      n_vec++;
      if (ir[0] !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready: got %b want 1", v, ir[0]); end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ov[0] !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid: got %b want 0", v, ov[0]); end
      tick();
      @(negedge clk);
      n_vec += 4;
      if (ov[0] !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid: got %b want 1", v, ov[0]); end
      if (od[0][31:0] !== tbl[v].e) begin n_err++; $display("FAIL dir%0d_data: got %h want %h", v, od[0][31:0], tbl[v].e); end
      if (oc[0] !== tbl[v].c) begin n_err++; $display("FAIL dir%0d_carry: got %b want %b", v, oc[0], tbl[v].c); end
      if (oz[0] !== (tbl[v].e == 32'h0)) begin n_err++; $display("FAIL dir%0d_zero: got %b want %b", v, oz[0], (tbl[v].e == 32'h0)); end
      tick();
    end
  endtask

  task automatic test_fill();
    logic [65:0] exp0;
    logic [65:0] snap;
    exp0 = '0;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      @(negedge clk);
      n_vec++;
      if (ir[0] !== (i < 2)) begin n_err++; $display("FAIL fill_ready%0d: got %b want %b", i, ir[0], (i < 2)); end
      if (i == 0) exp0 = f_ref(32, din, in_type, int'(amt) % 32);
      tick();
    end
    @(negedge clk);
    snap = {od[0], oc[0], oz[0]};
    n_vec += 2;
    if (ov[0] !== 1'b1) begin n_err++; $display("FAIL fill_valid: got %b want 1", ov[0]); end
    if (snap !== exp0) begin n_err++; $display("FAIL fill_result: got %h want %h", snap, exp0); end
    tick();
    @(negedge clk);
    n_vec++;
    if ({od[0], oc[0], oz[0]} !== snap) begin n_err++; $display("FAIL fill_stable: got %h want %h", {od[0], oc[0], oz[0]}, snap); end
    tick();
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (ir[0] !== 1'b1) begin n_err++; $display("FAIL fill_resume_ready: got %b want 1", ir[0]); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    in_valid = 1'b1;
    in_type  = SHIFT_NONE;
    din      = 64'hF0E1_D2C3_B4A5_9687;
    amt      = 6'd0;
    tick();
    din      = 64'h1357_9BDF_2468_ACE0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (ov[1] !== 1'b1) begin n_err++; $display("FAIL inflight_pre_valid16: got %b want 1", ov[1]); end
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_vec += 4;
      if (ov[d] !== 1'b0) begin n_err++; $display("FAIL arst_valid[%0d]: got %b want 0", d, ov[d]); end
      if (od[d] !== 64'h0) begin n_err++; $display("FAIL arst_data[%0d]: got %h want 0", d, od[d]); end
      if (oc[d] !== 1'b0) begin n_err++; $display("FAIL arst_carry[%0d]: got %b want 0", d, oc[d]); end
      if (oz[d] !== 1'b0) begin n_err++; $display("FAIL arst_zero[%0d]: got %b want 0", d, oz[d]); end
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
          n_err++;
          $display("FAIL arst_discard[%0d] cyc %0d: got valid %b ready %b want 0/1", d, c, ov[d], ir[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [65:0] q [3][$];
    logic [65:0] snap [3];
    logic        stall_prev [3];
    logic [65:0] exp_v;
    int          n_acc [3];
    for (int d = 0; d < 3; d++) begin
      stall_prev[d] = 1'b0;
      snap[d] = '0;
      n_acc[d] = 0;
    end
    do_reset();
    for (int i = 0; i < 170; i++) begin
      if (i < 150) begin
        randomize_inputs();
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 1) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (stall_prev[d]) begin
          n_vec++;
          if ({od[d], oc[d], oz[d]} !== snap[d]) begin
            n_err++;
            $display("FAIL b2b_stable[%0d] cyc %0d: got %h want %h", d, i, {od[d], oc[d], oz[d]}, snap[d]);
          end
        end
        if (in_valid && ir[d]) begin
          q[d].push_back(f_ref(wid(d), din, in_type, int'(amt) % wid(d)));
          n_acc[d]++;
        end
        if (ov[d] && out_ready) begin
          n_vec++;
          if (q[d].size() == 0) begin
            n_err++;
            $display("FAIL b2b_extra[%0d] cyc %0d: got result %h want none", d, i, od[d]);
          end else begin
            exp_v = q[d].pop_front();
            if ({od[d], oc[d], oz[d]} !== exp_v) begin
              n_err++;
              $display("FAIL b2b_result[%0d] cyc %0d: got %h want %h", d, i, {od[d], oc[d], oz[d]}, exp_v);
            end
          end
        end
        stall_prev[d] = ov[d] && !out_ready;
        snap[d] = {od[d], oc[d], oz[d]};
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      n_vec += 2;
      if (q[d].size() != 0) begin n_err++; $display("FAIL b2b_lost[%0d]: got %0d pending want 0", d, q[d].size()); end
      if (n_acc[d] < 16) begin n_err++; $display("FAIL b2b_accepted[%0d]: got %0d want >= 16", d, n_acc[d]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_type   = SHIFT_NONE;
    din       = '0;
    amt       = '0;
    test_reset();
    test_directed();
    test_fill();
    test_reset_inflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
